// File: rtl/bus_seq_key_if.sv
// Bus-side signal bundle for the snooping key/unlock engine.
// master: CPU/bus side driving accesses; slave: the key engine.
// Ports: sel_n, strobe, addr, br_w (access); resp_q, resp_oe, unlocked, key_idx (engine).
interface bus_seq_key_if #(
    parameter int ADDR_W = 14,
    parameter int RESP_W = 2
);
    logic              sel_n;
    logic              strobe;
    logic [ADDR_W-1:0] addr;
    logic              br_w;
    logic [RESP_W-1:0] resp_q;
    logic              resp_oe;
    logic              unlocked;
    logic [3:0]        key_idx;

    modport master (
        output sel_n, strobe, addr, br_w,
        input  resp_q, resp_oe, unlocked, key_idx
    );

    modport slave (
        input  sel_n, strobe, addr, br_w,
        output resp_q, resp_oe, unlocked, key_idx
    );
endinterface

// File: rtl/bus_seq_key.sv
// Purpose: snoops reads in a decoded window, matches a nibble key sequence, then streams LFSR bits.
// Latency: response drive is combinational in the hit cycle; state/unlocked/key_idx update at the next edge.
// Backpressure: none; every strobe is consumed in its own cycle.
// Ports: clk, rst_n (async active-low) plus the bus_seq_key_if slave modport
//   (sel_n, strobe, addr, br_w in; resp_q, resp_oe, unlocked, key_idx out).
// Optional: define BUS_SEQ_KEY_TIMEOUT_EN to relock after TIMEOUT_CYC idle cycles.
module bus_seq_key #(
    parameter int                      ADDR_W      = 14,
    parameter logic [ADDR_W-1:0]       WIN_BASE    = 14'h1000,
    parameter logic [ADDR_W-1:0]       WIN_MASK    = 14'h3000,
    parameter int                      NIB_LSB     = 4,
    parameter int                      NIB_W       = 4,
    parameter int                      KEY_LEN     = 4,
    parameter logic [KEY_LEN*NIB_W-1:0] KEY_SEQ    = 16'h5A3C,
    parameter int                      LFSR_W      = 6,
    parameter logic [LFSR_W-1:0]       LFSR_SEED   = 6'h01,
    parameter int                      RESP_W      = 2,
    parameter int                      STREAM_LEN  = 8,
    parameter int                      TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_seq_key_if.slave  bus
);

    typedef enum logic {
        LOCKED = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        key_idx_q, key_idx_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              hit;
    logic              miss;
    logic [NIB_W-1:0]  nib;
    logic [NIB_W-1:0]  key_cur;
    logic [NIB_W-1:0]  key_first;
    logic [3:0]        key_next;
    logic [7:0]        cnt_inc;

    // Access classification.
    always_comb begin
        hit  = bus.strobe & ~bus.sel_n & bus.br_w & ((bus.addr & WIN_MASK) == WIN_BASE);
        miss = bus.strobe & ~hit;
        nib  = bus.addr[NIB_LSB +: NIB_W];
    end

    // Key element at the current match index; a constant-index loop keeps
    // the selection free of out-of-range part-selects.
    always_comb begin
        key_cur   = '0;
        key_first = KEY_SEQ[NIB_W-1:0];
        for (int i = 0; i < KEY_LEN; i++) begin
            if (key_idx_q == 4'(i)) begin
                key_cur = KEY_SEQ[i*NIB_W +: NIB_W];
            end
        end
    end

`ifdef BUS_SEQ_KEY_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        idle_expire;

    // A strobe in the expiry cycle clears the counter and wins over the timeout.
    assign idle_expire = ~bus.strobe & (idle_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (bus.strobe) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + 16'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        key_idx_d = key_idx_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        key_next  = '0;
        cnt_inc   = cnt_q + 8'd1;

        case (state_q)
            LOCKED: begin
                if (hit) begin
                    // A wrong nibble that happens to be the first key
                    // element starts a fresh attempt rather than losing it.
                    if (nib == key_cur) begin
                        key_next = key_idx_q + 4'd1;
                    end else if (nib == key_first) begin
                        key_next = 4'd1;
                    end else begin
                        key_next = 4'd0;
                    end

                    if (key_next == 4'(KEY_LEN)) begin
                        state_d   = STREAM;
                        key_idx_d = '0;
                        lfsr_d    = LFSR_SEED;
                        cnt_d     = '0;
                    end else begin
                        key_idx_d = key_next;
                    end
                end else if (miss) begin
                    key_idx_d = '0;
                end
            end

            STREAM: begin
                if (hit) begin
                    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};
                    if (cnt_inc == 8'(STREAM_LEN)) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (miss) begin
                    // Any foreign access aborts the stream on the spot.
                    state_d   = LOCKED;
                    key_idx_d = '0;
                    cnt_d     = '0;
                end
            end

            default: begin
                state_d   = LOCKED;
                key_idx_d = '0;
                cnt_d     = '0;
            end
        endcase

`ifdef BUS_SEQ_KEY_TIMEOUT_EN
        if (idle_expire) begin
            state_d   = LOCKED;
            key_idx_d = '0;
            cnt_d     = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOCKED;
            key_idx_q <= '0;
            lfsr_q    <= LFSR_SEED;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_idx_q <= key_idx_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Response drive is purely combinational off the current hit so the
    // data lands in the same bus cycle as the read.
    always_comb begin
        bus.resp_oe  = (state_q == STREAM) & hit;
        bus.resp_q   = bus.resp_oe ? lfsr_q[RESP_W-1:0] : '0;
        bus.unlocked = (state_q == STREAM);
        bus.key_idx  = key_idx_q;
    end

endmodule

// File: doc/bus_seq_key.md
Name: bus_seq_key

Overview:
- Parametrised bus-snooping key/unlock engine; successor to the single-PAL address-sequence lock.
- Watches CPU accesses to a decoded address window and matches a programmable sequence of address nibbles.
- Once the sequence matches, it streams LFSR-derived response bits onto the data bus for a bounded number of reads.
- Sits beside the cartridge/ROM decode on the CPU bus; single-clock, with an access strobe instead of a strobe-clocked register.

Parameters:
ADDR_W, 14, address width
WIN_BASE, 14'h1000, window match value after masking
WIN_MASK, 14'h3000, address bits compared for window decode
NIB_LSB, 4, LSB position of the key nibble within addr
NIB_W, 4, key element width
KEY_LEN, 4, number of key elements (1..15)
KEY_SEQ, 16'h5A3C, packed key; element i = KEY_SEQ[i*NIB_W +: NIB_W]; element 0 is sent first
LFSR_W, 6, response LFSR width
LFSR_SEED, 6'h01, LFSR value loaded on unlock (must be nonzero)
RESP_W, 2, response bits driven per read
STREAM_LEN, 8, responses served before automatic relock (1..255)
TIMEOUT_CYC, 1024, idle cycles before relock (only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
sel_n  in  1  chip select from upstream decode, active low
strobe  in  1  one-cycle pulse marking a valid bus access
addr  in  ADDR_W  bus address, valid when strobe=1
br_w  in  1  1=read, 0=write
resp_q  out  RESP_W  response data to the bus
resp_oe  out  1  response drive enable (tristate control at top level)
unlocked  out  1  1 while in the STREAM state
key_idx  out  4  current match index (debug)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n, clocked on clk). Reset forces state=LOCKED, key_idx=0, lfsr=LFSR_SEED, stream count=0, resp_oe=0, resp_q=0, unlocked=0.
- hit = strobe & ~sel_n & br_w & ((addr & WIN_MASK) == WIN_BASE).
- nib = addr[NIB_LSB +: NIB_W].
- miss = strobe & ~hit. This covers any other access, including writes or reads outside the window.
- strobe=0: all state is held (subject to the optional timeout).
- LOCKED state, on hit:
  - If nib == KEY[key_idx], then key_idx+1.
  - Otherwise, if nib == KEY[0], key_idx=1.
  - Otherwise, key_idx=0.
  - When the incremented key_idx would equal KEY_LEN, go to STREAM with lfsr=LFSR_SEED, count=0, key_idx=0.
  - resp_oe stays 0 throughout LOCKED, including on the completing hit.
- LOCKED state, on miss: key_idx=0.
- STREAM state, on hit:
  - Combinationally in the same cycle: resp_oe=1, resp_q=lfsr[RESP_W-1:0]. Zero added latency.
  - At the clock edge: lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1]^lfsr[LFSR_W-2]}, and count+1.
  - If count+1 == STREAM_LEN, go to LOCKED.
  - The nibble value is ignored.
- STREAM state, on miss: go to LOCKED immediately (key_idx=0, count=0). resp_oe=0 in that cycle.
- resp_oe is 0 whenever strobe=0. resp_q is 0 whenever resp_oe=0.
- unlocked=1 exactly while state=STREAM (registered).
- Boundaries:
  - KEY_LEN=1: a single matching hit unlocks.
  - A mismatch that equals KEY[0] restarts the match at index 1.
  - If rst_n is asserted mid-stream, the next unlock restarts the LFSR at LFSR_SEED.
  - The LFSR never reaches 0 from a nonzero seed.
  - count is 8 bits wide and never wraps within a stream.

Optional Feature:
- Macro: BUS_SEQ_KEY_TIMEOUT_EN.
- When defined:
  - A 16-bit idle counter clears on every strobe and increments otherwise.
  - On reaching TIMEOUT_CYC-1, any state returns to LOCKED (key_idx=0, count=0).
  - An expiry in the same cycle as a strobe is ignored, because the strobe wins.
- When undefined: no counter; state is held indefinitely with no strobe.

Test Plan:
- Unlock: reads at 0x10C0, 0x1030, 0x10A0, 0x1050 -> key_idx 1,2,3, then unlocked=1; resp_oe=0 on all four.
- Stream: 8 further reads at 0x1000 -> resp_q = 01,10,00,00,00,01,11,10 with resp_oe=1 each cycle; unlocked drops after the 8th.
- Restart on mismatch: reads 0x10C0, 0x1030, 0x10C0, 0x1030, 0x10A0, 0x1050 -> unlocks after the 6th read (third read restarts at index 1).
- Abort: unlock, 2 stream reads, then a write to 0x1000 -> resp_oe=0 on the write, unlocked=0 next cycle; re-unlock gives resp_q=01 first.
- Async reset: pulse rst_n low between clock edges mid-key and mid-stream -> all outputs 0 immediately; key_idx=0.
- BUS_SEQ_KEY_TIMEOUT_EN with TIMEOUT_CYC=16: unlock, then 16 idle cycles -> unlocked=0; with the macro undefined, unlocked stays 1.
